// File: rtl/prm_edge_scan_ctrl_if.sv
// Handshake bundle between the scene-code source, the edge-scan controller and the
// bitmap consumer. The master side feeds voxel codes and sinks bitmap words.
interface prm_edge_scan_ctrl_if #(
    parameter int unsigned CODE_W = 15,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned IDX_W  = 4
);
    logic              obs_valid;
    logic              obs_ready;
    logic [CODE_W-1:0] obs_code;
    logic              obs_last;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport master (
        output obs_valid, obs_code, obs_last, out_ready,
        input  obs_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  obs_valid, obs_code, obs_last, out_ready,
        output obs_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/prm_edge_scan_ctrl.sv
// PRM edge-scan controller: presents each occupied-voxel code of a scene to the checker
// bank, ORs the returned edge masks into a blocked-edge bitmap, and on scene end streams
// the bitmap out word by word before rearming for the next scene.
module prm_edge_scan_ctrl #(
    parameter int unsigned NUM_CHK = 512,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned CODE_W  = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prm_edge_scan_ctrl_if.slave  bus,
    output logic [CODE_W-1:0]    o_chk_vec,
    input  logic [NUM_CHK-1:0]   i_chk_mask,
    output logic [15:0]          o_scene_codes,
    output logic                 o_busy
);
    localparam int unsigned NW    = NUM_CHK / WORD_W;
    localparam int unsigned IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    typedef enum logic [1:0] {StAccum, StSettle, StDrain} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [NUM_CHK-1:0] r_acc;
    logic [CODE_W-1:0]  r_chk_vec;
    logic               r_pend;
    logic               r_last_pend;
    logic [IDX_W-1:0]   r_idx;
    logic [15:0]        r_scene_codes;

    logic               w_obs_fire;
    logic               w_out_fire;
    logic               w_drain_done;

    assign w_obs_fire   = (r_state == StAccum) && bus.obs_valid;
    assign w_out_fire   = (r_state == StDrain) && bus.out_ready;
    assign w_drain_done = w_out_fire && (r_idx == LAST_IDX);

    // Next-state decode and handshake strobes
    always_comb begin
        w_state_d     = r_state;
        bus.obs_ready = 1'b0;
        bus.out_valid = 1'b0;
        unique case (r_state)
            StAccum: begin
                bus.obs_ready = 1'b1;
                if (bus.obs_valid && bus.obs_last) begin
                    w_state_d = StSettle;
                end
            end
            StSettle: begin
                // last_pend is always set on entry; never drain a scene lacking its closing code
                if (r_last_pend) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready && (r_idx == LAST_IDX)) begin
                    w_state_d = StAccum;
                end
            end
            default: w_state_d = StAccum;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StAccum;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Code capture, pending-sample flags and saturating scene code counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_vec     <= '0;
            r_pend        <= 1'b0;
            r_last_pend   <= 1'b0;
            r_scene_codes <= '0;
        end else if (w_obs_fire) begin
            r_chk_vec   <= bus.obs_code;
            r_pend      <= 1'b1;
            r_last_pend <= bus.obs_last;
            if (r_scene_codes != 16'hFFFF) begin
                r_scene_codes <= r_scene_codes + 16'd1;
            end
        end else begin
            r_pend <= 1'b0;
            if (r_state == StSettle) begin
                r_last_pend <= 1'b0;
            end
            if (w_drain_done) begin
                r_scene_codes <= '0;
            end
        end
    end

    // Sticky blocked-edge bitmap: fold checker masks one cycle after each new code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_drain_done) begin
            r_acc <= '0;
        end else if (r_pend) begin
            r_acc <= r_acc | i_chk_mask;
        end
    end

    // Output word index; wraps to 0 after the final word so each scene drains from 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_out_fire) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    assign bus.out_data   = r_acc[r_idx*WORD_W +: WORD_W];
    assign bus.out_idx    = r_idx;
    assign bus.out_last   = (r_state == StDrain) && (r_idx == LAST_IDX);
    assign o_chk_vec      = r_chk_vec;
    assign o_scene_codes  = r_scene_codes;
    assign o_busy         = (r_state != StAccum) || r_pend;
endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Bench for prm_edge_scan_ctrl: a behavioural checker bank drives chk_mask from chk_vec,
// and each scene's expected bitmap is the OR of the bank masks of its codes.
module tb_prm_edge_scan_ctrl;
    localparam int unsigned NUM_CHK = 512;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CODE_W  = 15;
    localparam int unsigned NW      = NUM_CHK / WORD_W;
    localparam int unsigned IDX_W   = 4;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic [CODE_W-1:0]  chk_vec;
    logic [NUM_CHK-1:0] chk_mask;
    logic [15:0]        scene_codes;
    logic               busy;

    int                 mask_mode = 0;
    int                 n_total   = 0;
    int                 n_bad     = 0;
    logic [CODE_W-1:0]  scene_q[$];
    logic [NUM_CHK-1:0] exp_map;
    int                 exp_codes;

    always #5 clk = ~clk;

    prm_edge_scan_ctrl_if #(.CODE_W(CODE_W), .WORD_W(WORD_W), .IDX_W(IDX_W)) bus ();

    prm_edge_scan_ctrl #(.NUM_CHK(NUM_CHK), .WORD_W(WORD_W), .CODE_W(CODE_W)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .o_chk_vec     (chk_vec),
        .i_chk_mask    (chk_mask),
        .o_scene_codes (scene_codes),
        .o_busy        (busy)
    );

    // Checker bank: mode 0 = directed table, 1 = hashed masks, 2 = nothing blocked
    function automatic logic [NUM_CHK-1:0] bank_mask(input logic [CODE_W-1:0] c, input int mode);
        logic [NUM_CHK-1:0] m;
        int v;
        m = '0;
        v = int'(c);
        if (mode == 0) begin
            case (c)
                15'h1234: begin m[5] = 1'b1; m[40] = 1'b1; end
                15'h0001: m[0] = 1'b1;
                15'h0002: begin m[0] = 1'b1; m[511] = 1'b1; end
                15'h0003: m[33] = 1'b1;
                default:  m = '0;
            endcase
        end else if (mode == 1) begin
            m[(v * 37) % NUM_CHK]      = 1'b1;
            m[(v * 101 + 7) % NUM_CHK] = 1'b1;
            if (c[0]) m[(v ^ 341) % NUM_CHK] = 1'b1;
        end
        return m;
    endfunction

    always_comb chk_mask = bank_mask(chk_vec, mask_mode);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_model();
        exp_map = '0;
        foreach (scene_q[i]) exp_map = exp_map | bank_mask(scene_q[i], mask_mode);
        exp_codes = (scene_q.size() > 65535) ? 65535 : scene_q.size();
    endtask

    // Feed scene_q starting at a negedge; ends at the negedge after the final accept
    task automatic send_scene(input int gap_max, input bit hold_valid);
        int n;
        n = scene_q.size();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            bus.obs_valid = 1'b1;
            bus.obs_code  = scene_q[i];
            bus.obs_last  = (i == n - 1);
            check_eq("obs_ready_accum", bus.obs_ready, 1'b1);
            @(negedge clk);
            check_eq("scene_codes_accept", scene_codes, i + 1);
            check_eq("chk_vec", chk_vec, scene_q[i]);
            bus.obs_valid = 1'b0;
            bus.obs_last  = 1'b0;
        end
        check_eq("busy_settle", busy, 1'b1);
        check_eq("obs_ready_settle", bus.obs_ready, 1'b0);
        if (hold_valid) begin
            bus.obs_valid = 1'b1;
            bus.obs_code  = CODE_W'($urandom);
            bus.obs_last  = 1'($urandom_range(0, 1));
        end
    endtask

    // pattern: 0 = always ready, 1 = random, 2 = one on / two off; abort_at < 0 means none
    task automatic drain(input int pattern, input int abort_at);
        int got_cnt;
        int cyc;
        bit holding;
        bit aborted;
        bit rdy;
        logic [WORD_W-1:0] held_data;
        logic [IDX_W-1:0]  held_idx;
        got_cnt = 0;
        cyc = 0;
        holding = 1'b0;
        aborted = 1'b0;
        held_data = '0;
        held_idx = '0;
        while (got_cnt < int'(NW) && cyc < 2000 && !aborted) begin
            if (got_cnt == abort_at && bus.out_valid) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_out_valid", bus.out_valid, 1'b0);
                check_eq("abort_out_last", bus.out_last, 1'b0);
                check_eq("abort_chk_vec", chk_vec, '0);
                check_eq("abort_scene_codes", scene_codes, '0);
                check_eq("abort_busy", busy, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                bus.obs_valid = 1'b0;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check_eq("abort_obs_ready", bus.obs_ready, 1'b1);
                check_eq("abort_out_valid_rel", bus.out_valid, 1'b0);
                aborted = 1'b1;
            end else begin
                case (pattern)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = (cyc % 3 == 0);
                endcase
                bus.out_ready = rdy;
                if (bus.out_valid) begin
                    if (holding) begin
                        check_eq("stall_data", bus.out_data, held_data);
                        check_eq("stall_idx", bus.out_idx, held_idx);
                    end
                    check_eq("obs_ready_drain", bus.obs_ready, 1'b0);
                    check_eq("scene_codes_drain", scene_codes, exp_codes);
                    check_eq("out_last", bus.out_last, got_cnt == int'(NW) - 1);
                    if (rdy) begin
                        check_eq("out_idx", bus.out_idx, got_cnt);
                        check_eq("out_data", bus.out_data, exp_map[got_cnt*WORD_W +: WORD_W]);
                        got_cnt++;
                        holding = 1'b0;
                    end else begin
                        holding   = 1'b1;
                        held_data = bus.out_data;
                        held_idx  = bus.out_idx;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.obs_valid = 1'b0;
        bus.out_ready = 1'b0;
        if (!aborted) begin
            check_eq("drain_words", got_cnt, NW);
            check_eq("post_out_valid", bus.out_valid, 1'b0);
            check_eq("post_scene_codes", scene_codes, '0);
            check_eq("post_obs_ready", bus.obs_ready, 1'b1);
            check_eq("post_busy", busy, 1'b0);
        end
    endtask

    task automatic run_scene(input int gap_max, input bit hold, input int pattern, input int abort_at);
        build_model();
        send_scene(gap_max, hold);
        drain(pattern, abort_at);
    endtask

    task automatic random_scene(input int max_len);
        int len;
        len = $urandom_range(1, max_len);
        scene_q.delete();
        for (int i = 0; i < len; i++) scene_q.push_back(CODE_W'($urandom_range(0, 32767)));
    endtask

    initial begin
        bus.obs_valid = 1'b0;
        bus.obs_code  = '0;
        bus.obs_last  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_obs_ready", bus.obs_ready, 1'b1);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_chk_vec", chk_vec, '0);
        check_eq("rst_scene_codes", scene_codes, '0);

        // Single-code scene
        mask_mode = 0;
        scene_q.delete();
        scene_q.push_back(15'h1234);
        run_scene(0, 1'b0, 0, -1);

        // Back-to-back codes, stalled drain with obs_valid held high
        scene_q.delete();
        scene_q.push_back(15'h0001);
        scene_q.push_back(15'h0002);
        scene_q.push_back(15'h0003);
        run_scene(0, 1'b1, 2, -1);

        // Randomised scenes with hashed bank responses
        mask_mode = 1;
        for (int s = 0; s < 6; s++) begin
            random_scene(12);
            run_scene(2, 1'($urandom_range(0, 1)), 1, -1);
        end

        // Empty bank response still yields NW zero words
        mask_mode = 2;
        random_scene(6);
        run_scene(1, 1'b0, 0, -1);

        // Reset mid-drain, then a clean scene must carry no residue
        mask_mode = 1;
        random_scene(10);
        run_scene(1, 1'b0, 0, 7);
        random_scene(10);
        run_scene(1, 1'b0, 1, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/prm_edge_scan_ctrl.md
Name: prm_edge_scan_ctrl

Overview:
- Drives the PRM obstacle-check logic bank (NUM_CHK combinational edge checkers sharing one 15-bit voxel code bus) from a stream of occupied-voxel codes belonging to one scene.
- ORs every returned edge_mask vector into a scene-wide blocked-edge bitmap.
- On scene end, streams the bitmap out as WORD_W-bit words to the roadmap/graph-search side, then rearms for the next scene.

Parameters:
- NUM_CHK, 512, number of edge checkers (edges) in the bank; must be a multiple of WORD_W.
- WORD_W, 32, output word width.
- CODE_W, 15, voxel code width (checker inputs A..O; A = bit 0).
- NW, NUM_CHK/WORD_W (derived localparam), words per bitmap.

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, asynchronous active-low reset.
- obs_valid, input, 1, voxel code valid.
- obs_ready, output, 1, controller accepts code.
- obs_code, input, CODE_W, occupied voxel code.
- obs_last, input, 1, final code of scene (qualified by obs_valid).
- chk_vec, output, CODE_W, registered code driven to all checkers.
- chk_mask, input, NUM_CHK, edge_mask outputs of checkers 0..NUM_CHK-1.
- out_valid, output, 1, bitmap word valid.
- out_ready, input, 1, downstream accepts word.
- out_data, output, WORD_W, bitmap bits [idx*WORD_W +: WORD_W]; 1 = edge blocked.
- out_idx, output, clog2(NW), word index.
- out_last, output, 1, high with word NW-1.
- scene_codes, output, 16, codes accepted in current/last scene, saturating at 0xFFFF.
- busy, output, 1, high when state is not ACCUM, or when pend = 1.

Behaviour:

Reset (async, rst_n = 0):
- State = ACCUM, acc = 0, chk_vec = 0, pend = 0, last_pend = 0, word index = 0, scene_codes = 0.
- obs_ready = 1 and out_valid = 0 once reset is released.

Handshakes:
- Transfer occurs when valid & ready are both high at a rising clk edge.
- Source must hold obs_code and obs_last stable while obs_valid is high and obs_ready is low.
- out_data, out_idx and out_last are stable while out_valid is high and out_ready is low.

States:
- ACCUM, SETTLE, DRAIN.

ACCUM:
- obs_ready = 1.
- On accept: chk_vec <= obs_code, pend <= 1, last_pend <= obs_last, scene_codes += 1 (saturating).
- If obs_last is accepted, next state = SETTLE. Otherwise stay in ACCUM.
- Back-to-back accepts are allowed, one per cycle.

Mask sampling (any state, when pend = 1):
- acc <= acc | chk_mask, sampled one cycle after chk_vec updates (checker settle budget is 1 cycle).
- pend clears unless a new accept occurs in the same cycle.
- Latency: code accepted at cycle t is reflected in acc at the end of cycle t+1.

SETTLE:
- obs_ready = 0.
- The final pending sample is folded into acc this cycle.
- Next state = DRAIN with word index 0.

DRAIN:
- obs_ready = 0, out_valid = 1.
- out_data = acc[idx*WORD_W +: WORD_W], out_idx = idx, out_last = (idx == NW-1).
- On out handshake: idx += 1.
- On handshake with idx == NW-1: acc <= 0, idx <= 0, scene_codes <= 0, next state = ACCUM.
- out_valid drops for at least 1 cycle between scenes.

Boundary conditions:
- Single-code scene: first accepted code carries obs_last; bitmap equals that code's mask.
- obs_valid held high during SETTLE/DRAIN is ignored; no accept occurs.
- out_ready held low indefinitely: hold the word and stall; acc is unchanged.
- Empty bank response (chk_mask = 0 for every code): all-zero words are still output, NW of them.
- Sticky OR: a blocked bit never clears within a scene.
- chk_vec holds its last value outside accepts.
- rst_n asserted mid-DRAIN or mid-ACCUM: immediate return to reset state; partial bitmap is discarded and no out_last is issued.

Test Plan:
1. Reset release, no traffic -> obs_ready = 1, out_valid = 0, busy = 0, chk_vec = 0, scene_codes = 0.
2. Single code 0x1234 with obs_last; bench bank returns mask bit 5 and bit 40 -> out words: idx0 = 0x00000020, idx1 = 0x00000100, idx2..15 = 0; out_last only on idx15; obs_ready low from the accept through the final handshake.
3. Three back-to-back codes with masks {bit0}, {bit0, bit511}, {bit33}; last on third -> word0 = 0x00000001, word1 = 0x00000002, word15 = 0x80000000; scene_codes = 3 during drain.
4. Drain with out_ready toggling 1 cycle on / 2 cycles off -> each word is held stable while stalled; 16 transfers in order 0..15 with no duplicates; obs_ready stays 0 throughout.
5. Second scene after the first -> acc cleared; bits from scene 1 are absent from scene 2 output; scene_codes restarts at 1 on the first accept.
6. rst_n pulsed low at DRAIN idx = 7 -> outputs immediately return to reset values; the next scene's bitmap has no residue from the aborted scene.
